// File: rtl/matmul_pkg.sv
// matmul_pkg
// Shared definitions for the matrix-multiply operand fetch slice: data and
// memory-address widths, the fetch FSM state type, and the field layout of
// the packed memory request word (A address high byte, B address low byte).
package matmul_pkg;

  localparam int DATA_W  = 16;
  localparam int MADDR_W = 8;

  // Request word layout: A address in [15:8], B address in [7:0].
  localparam int A_FIELD_HI = 15;
  localparam int A_FIELD_LO = 8;
  localparam int B_FIELD_HI = 7;
  localparam int B_FIELD_LO = 0;

  // One buffered operand pair: {last, a, b}.
  localparam int PAIR_W = 2 * DATA_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    GAP,
    DRAIN,
    DONE
  } fetch_state_t;

  // Packs the A and B word addresses into one memory request word.
  function automatic logic [2*MADDR_W-1:0] pack_address(
    input logic [MADDR_W-1:0] a_addr,
    input logic [MADDR_W-1:0] b_addr
  );
    logic [2*MADDR_W-1:0] word;
    word = '0;
    word[A_FIELD_HI:A_FIELD_LO] = a_addr;
    word[B_FIELD_HI:B_FIELD_LO] = b_addr;
    return word;
  endfunction

endpackage

// File: rtl/operand_fifo.sv
// operand_fifo
// Synchronous FIFO holding operand pairs between memory capture and the MAC
// stream. A push and a pop in the same cycle are both honoured, even when
// the FIFO is full.
// Ports:
//   clk, rst          clock, synchronous active-high reset (empties the FIFO)
//   push, push_data   write request and data
//   pop               read request (ignored when empty)
//   head              oldest entry (meaningful only when !empty)
//   count, full, empty  occupancy status
module operand_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = storage[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap explicitly so any depth
  // works, not only powers of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      storage[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/matmul_operand_fetch.sv
// matmul_operand_fetch
// Read initiator for the operand memory. Walks C = A x B in i, j, k order,
// issuing one packed request {A[i][k], B[k][j]} at a time, captures the
// returned words MEM_LAT cycles later and streams them to the MAC datapath
// through a small FIFO, marking the last pair of each dot product.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start, a_base, b_base  begin a product (sampled only in IDLE)
//   busy, done             product in progress / one-cycle completion pulse
//   mem_address            {A address, B address} request word
//   mem_write_en           always 0
//   mem_q1, mem_q2         A and B read data
//   op_valid, op_ready     operand stream handshake
//   op_a, op_b, op_last    operand pair and end-of-dot-product marker
module matmul_operand_fetch
  import matmul_pkg::*;
#(
  parameter int N          = 4,
  parameter int MEM_LAT    = 3,
  parameter int ISSUE_GAP  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [MADDR_W-1:0]   a_base,
  input  logic [MADDR_W-1:0]   b_base,
  output logic                 busy,
  output logic                 done,
  output logic [2*MADDR_W-1:0] mem_address,
  output logic                 mem_write_en,
  input  logic [DATA_W-1:0]    mem_q1,
  input  logic [DATA_W-1:0]    mem_q2,
  output logic                 op_valid,
  input  logic                 op_ready,
  output logic [DATA_W-1:0]    op_a,
  output logic [DATA_W-1:0]    op_b,
  output logic                 op_last
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N - 1);

  fetch_state_t state;
  fetch_state_t next_state;

  logic [IDX_W-1:0]   i_idx;
  logic [IDX_W-1:0]   j_idx;
  logic [IDX_W-1:0]   k_idx;
  logic [MADDR_W-1:0] a_ptr;
  logic [MADDR_W-1:0] b_ptr;
  logic [MADDR_W-1:0] b_base_r;
  logic [GAP_W-1:0]   gap_cnt;

  logic               req_valid;
  logic               req_last;
  logic [MEM_LAT-1:0] pipe_valid;
  logic [MEM_LAT-1:0] pipe_last;
  logic [CNT_W-1:0]   inflight;

  logic               issue;
  logic               credit;
  logic               final_req;
  logic               capture;

  logic               fifo_pop;
  logic [PAIR_W-1:0]  fifo_head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_full;
  logic               fifo_empty;

  assign mem_write_en = 1'b0;

  // A request may go out only while every pair already buffered or still
  // coming back from memory has a guaranteed FIFO slot.
  assign credit = !fifo_full &&
                  (({1'b0, fifo_count} + {1'b0, inflight}) < (CNT_W + 1)'(FIFO_DEPTH));
  assign final_req = (i_idx == IDX_MAX) && (j_idx == IDX_MAX) && (k_idx == IDX_MAX);
  assign capture   = pipe_valid[MEM_LAT-1];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and control decode.
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        busy = 1'b1;
        if (credit) begin
          issue = 1'b1;
          if (final_req) begin
            next_state = DRAIN;
          end else if (ISSUE_GAP > 1) begin
            next_state = GAP;
          end
        end
      end
      GAP: begin
        busy = 1'b1;
        if (gap_cnt <= GAP_W'(1)) begin
          next_state = ISSUE;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (inflight == '0 && fifo_empty) begin
          next_state = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Loop indices and address pointers. The pointers are advanced
  // incrementally so no multiplier is needed; all arithmetic wraps mod 256.
  always_ff @(posedge clk) begin
    if (rst) begin
      i_idx       <= '0;
      j_idx       <= '0;
      k_idx       <= '0;
      a_ptr       <= '0;
      b_ptr       <= '0;
      b_base_r    <= '0;
      gap_cnt     <= '0;
      mem_address <= '0;
    end else begin
      if (state == IDLE && start) begin
        i_idx    <= '0;
        j_idx    <= '0;
        k_idx    <= '0;
        a_ptr    <= a_base;
        b_ptr    <= b_base;
        b_base_r <= b_base;
      end
      if (issue) begin
        mem_address <= pack_address(a_ptr, b_ptr);
        gap_cnt     <= GAP_W'(ISSUE_GAP - 1);
        if (k_idx != IDX_MAX) begin
          k_idx <= k_idx + IDX_W'(1);
          a_ptr <= a_ptr + MADDR_W'(1);
          b_ptr <= b_ptr + MADDR_W'(N);
        end else begin
          k_idx <= '0;
          if (j_idx != IDX_MAX) begin
            j_idx <= j_idx + IDX_W'(1);
            a_ptr <= a_ptr - MADDR_W'(N - 1);
            b_ptr <= b_base_r + MADDR_W'(j_idx) + MADDR_W'(1);
          end else begin
            j_idx <= '0;
            i_idx <= i_idx + IDX_W'(1);
            a_ptr <= a_ptr + MADDR_W'(1);
            b_ptr <= b_base_r;
          end
        end
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - GAP_W'(1);
      end
    end
  end

  // Read-return tracking. req_valid marks the cycle the address is on the
  // bus; the shift register then counts MEM_LAT cycles so the exit bit lines
  // up with the cycle mem_q1/mem_q2 carry that request's data. Reset clears
  // the pipe, so data returning for discarded requests is never captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_valid  <= 1'b0;
      req_last   <= 1'b0;
      pipe_valid <= '0;
      pipe_last  <= '0;
      inflight   <= '0;
    end else begin
      req_valid     <= issue;
      req_last      <= issue && (k_idx == IDX_MAX);
      pipe_valid[0] <= req_valid;
      pipe_last[0]  <= req_last;
      for (int s = 1; s < MEM_LAT; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        pipe_last[s]  <= pipe_last[s-1];
      end
      case ({issue, capture})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign fifo_pop = op_valid && op_ready;

  operand_fifo #(
    .WIDTH (PAIR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .push_data ({pipe_last[MEM_LAT-1], mem_q1, mem_q2}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The stream shows zeros while empty so stale FIFO contents never leak out.
  assign op_valid = !fifo_empty;
  assign op_last  = fifo_empty ? 1'b0 : fifo_head[PAIR_W-1];
  assign op_a     = fifo_empty ? '0 : fifo_head[2*DATA_W-1:DATA_W];
  assign op_b     = fifo_empty ? '0 : fifo_head[DATA_W-1:0];

endmodule

// File: tb/tb_matmul_operand_fetch.sv
// tb_matmul_operand_fetch
// Drives three instances of matmul_operand_fetch (N = 2, 4 and 1), one at a
// time through a shared view selected by 'sel'. Each instance has its own
// memory model returning address-tagged words MEM_LAT cycles after the
// request. Expected addresses and pairs come from a direct i/j/k model.
module tb_matmul_operand_fetch;

  localparam int MEM_LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a_base;
  logic [7:0]  b_base;
  logic        op_ready;
  int          sel;

  logic        start_u   [3];
  logic        busy_u    [3];
  logic        done_u    [3];
  logic [15:0] maddr_u   [3];
  logic        wen_u     [3];
  logic [15:0] q1_u      [3];
  logic [15:0] q2_u      [3];
  logic        valid_u   [3];
  logic [15:0] opa_u     [3];
  logic [15:0] opb_u     [3];
  logic        last_u    [3];
  logic [15:0] d1 [3];
  logic [15:0] d2 [3];
  logic [15:0] d3 [3];

  logic        cur_busy, cur_done, cur_wen, cur_valid, cur_last;
  logic [15:0] cur_addr, cur_opa, cur_opb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign start_u[0] = start && (sel == 0);
  assign start_u[1] = start && (sel == 1);
  assign start_u[2] = start && (sel == 2);

  assign cur_busy  = busy_u[sel];
  assign cur_done  = done_u[sel];
  assign cur_wen   = wen_u[sel];
  assign cur_valid = valid_u[sel];
  assign cur_last  = last_u[sel];
  assign cur_addr  = maddr_u[sel];
  assign cur_opa   = opa_u[sel];
  assign cur_opb   = opb_u[sel];

  // Memory model: data for the address presented in cycle t appears in
  // cycle t + MEM_LAT, tagged with the word address it came from.
  always @(posedge clk) begin
    for (int u = 0; u < 3; u++) begin
      d1[u] <= maddr_u[u];
      d2[u] <= d1[u];
      d3[u] <= d2[u];
    end
  end

  always_comb begin
    for (int u = 0; u < 3; u++) begin
      q1_u[u] = {8'hA1, d3[u][15:8]};
      q2_u[u] = {8'hB2, d3[u][7:0]};
    end
  end

  matmul_operand_fetch #(.N(2), .MEM_LAT(MEM_LAT), .ISSUE_GAP(2), .FIFO_DEPTH(4)) u_n2 (
    .clk(clk), .rst(rst), .start(start_u[0]), .a_base(a_base), .b_base(b_base),
    .busy(busy_u[0]), .done(done_u[0]), .mem_address(maddr_u[0]), .mem_write_en(wen_u[0]),
    .mem_q1(q1_u[0]), .mem_q2(q2_u[0]), .op_valid(valid_u[0]), .op_ready(op_ready),
    .op_a(opa_u[0]), .op_b(opb_u[0]), .op_last(last_u[0])
  );

  matmul_operand_fetch #(.N(4), .MEM_LAT(MEM_LAT), .ISSUE_GAP(2), .FIFO_DEPTH(4)) u_n4 (
    .clk(clk), .rst(rst), .start(start_u[1]), .a_base(a_base), .b_base(b_base),
    .busy(busy_u[1]), .done(done_u[1]), .mem_address(maddr_u[1]), .mem_write_en(wen_u[1]),
    .mem_q1(q1_u[1]), .mem_q2(q2_u[1]), .op_valid(valid_u[1]), .op_ready(op_ready),
    .op_a(opa_u[1]), .op_b(opb_u[1]), .op_last(last_u[1])
  );

  matmul_operand_fetch #(.N(1), .MEM_LAT(MEM_LAT), .ISSUE_GAP(2), .FIFO_DEPTH(4)) u_n1 (
    .clk(clk), .rst(rst), .start(start_u[2]), .a_base(a_base), .b_base(b_base),
    .busy(busy_u[2]), .done(done_u[2]), .mem_address(maddr_u[2]), .mem_write_en(wen_u[2]),
    .mem_q1(q1_u[2]), .mem_q2(q2_u[2]), .op_valid(valid_u[2]), .op_ready(op_ready),
    .op_a(opa_u[2]), .op_b(opb_u[2]), .op_last(last_u[2])
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one product on unit 'unit'. stall: cycles op_ready is held low after
  // start. restart_at: cycle at which start is re-asserted for 3 cycles while
  // busy. abort_after: pulse reset once this many requests were seen.
  task automatic applyStimulus(input int unit, input int n, input logic [7:0] ab,
                               input logic [7:0] bb, input int stall,
                               input int restart_at, input int abort_after);
    int pairs = 0, lasts = 0, dones = 0, issues = 0, cyc = 0, tail = 0;
    int first_issue = -1, first_valid = -1, stalled_issues = 0;
    int unstable = 0, wen_hi = 0, late_valid = 0, late_busy = 0;
    int ii, jj, kk, total;
    bit finished = 0;
    bit held_v = 0;
    logic [15:0] prev_addr, held_a, held_b;
    logic [7:0]  ea, eb;

    total = n * n * n;
    sel = unit;
    a_base = ab;
    b_base = bb;
    @(negedge clk);
    prev_addr = cur_addr;
    start = 1'b1;
    op_ready = (stall == 0);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    checkOutput("busy_after_start", {31'd0, cur_busy}, 32'd1);

    while (!finished && cyc < 3000) begin
      if (cyc == stall) op_ready = 1'b1;
      start = (restart_at > 0 && cyc >= restart_at && cyc < restart_at + 3);
      if (cur_wen) wen_hi++;

      if (cur_addr != prev_addr) begin
        kk = issues % n;
        jj = (issues / n) % n;
        ii = issues / (n * n);
        ea = 8'(ab + ii * n + kk);
        eb = 8'(bb + kk * n + jj);
        checkOutput("req_addr", {16'd0, cur_addr}, {16'd0, ea, eb});
        if (issues == 0) first_issue = cyc;
        if (cyc < stall) stalled_issues++;
        issues++;
        prev_addr = cur_addr;
        if (abort_after > 0 && issues == abort_after) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          checkOutput("abort_valid", {31'd0, cur_valid}, 32'd0);
          checkOutput("abort_busy", {31'd0, cur_busy}, 32'd0);
          checkOutput("abort_addr", {16'd0, cur_addr}, 32'd0);
          for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (cur_valid) late_valid++;
            if (cur_busy) late_busy++;
          end
          checkOutput("stale_data_ignored", late_valid, 0);
          checkOutput("stays_idle", late_busy, 0);
          start = 1'b0;
          return;
        end
      end

      if (cur_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (!op_ready) begin
          if (held_v && (cur_opa != held_a || cur_opb != held_b)) unstable++;
          held_a = cur_opa;
          held_b = cur_opb;
          held_v = 1;
        end else begin
          kk = pairs % n;
          jj = (pairs / n) % n;
          ii = pairs / (n * n);
          ea = 8'(ab + ii * n + kk);
          eb = 8'(bb + kk * n + jj);
          checkOutput("op_a", {16'd0, cur_opa}, {16'd0, 8'hA1, ea});
          checkOutput("op_b", {16'd0, cur_opb}, {16'd0, 8'hB2, eb});
          checkOutput("op_last", {31'd0, cur_last}, {31'd0, kk == n - 1});
          if (cur_last) lasts++;
          pairs++;
          held_v = 0;
        end
      end

      if (cur_done) begin
        dones++;
        checkOutput("busy_with_done", {31'd0, cur_busy}, 32'd0);
      end
      if (dones > 0) tail++;
      if (tail > 6) finished = 1;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;

    if (!finished) checkOutput("timeout", 0, 1);
    checkOutput("pair_count", pairs, total);
    checkOutput("last_count", lasts, n * n);
    checkOutput("issue_count", issues, total);
    checkOutput("done_pulses", dones, 1);
    checkOutput("busy_end", {31'd0, cur_busy}, 32'd0);
    checkOutput("write_en_high", wen_hi, 0);
    checkOutput("first_latency", first_valid - first_issue, MEM_LAT + 1);
    if (stall > 0) begin
      checkOutput("stalled_issues", stalled_issues, 4);
      checkOutput("stalled_unstable", unstable, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    op_ready = 1'b0;
    sel = 0;
    a_base = '0;
    b_base = '0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      sel = u;
      #1;
      checkOutput("rst_busy", {31'd0, cur_busy}, 32'd0);
      checkOutput("rst_done", {31'd0, cur_done}, 32'd0);
      checkOutput("rst_valid", {31'd0, cur_valid}, 32'd0);
      checkOutput("rst_addr", {16'd0, cur_addr}, 32'd0);
      checkOutput("rst_op_ab", {cur_opa, cur_opb}, 32'd0);
      checkOutput("rst_last", {31'd0, cur_last}, 32'd0);
    end
    rst = 1'b0;

    $display("[TB] basic product N=2");
    applyStimulus(0, 2, 8'h10, 8'h20, 0, 0, 0);
    $display("[TB] backpressure N=4");
    applyStimulus(1, 4, 8'h00, 8'h40, 20, 0, 0);
    $display("[TB] address wrap N=4");
    applyStimulus(1, 4, 8'hFC, 8'hF8, 0, 0, 0);
    $display("[TB] reset mid-run");
    applyStimulus(1, 4, 8'h30, 8'h60, 0, 0, 10);
    applyStimulus(0, 2, 8'h50, 8'h70, 0, 0, 0);
    $display("[TB] N=1 product");
    applyStimulus(2, 1, 8'h05, 8'h09, 0, 0, 0);
    $display("[TB] start while busy");
    applyStimulus(0, 2, 8'h80, 8'h90, 0, 6, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
